mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative MIPS-style multiply/divide unit that owns the HI/LO register pair.
- Sits directly downstream of the register file: consumes the two read-port operands (R1 as rs, R2 as rt) and produces hi/lo.
- hi/lo are selected onto the register-file write_data path for MFHI/MFLO.
- Exposes busy so the control path stalls the PC while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  operation request, sampled on the rising edge
- op  in  3  operation code, sampled with start
- rs_val  in  WIDTH  operand A: multiplicand or dividend; source for MTHI/MTLO
- rt_val  in  WIDTH  operand B: multiplier or divisor
- busy  out  1  high while an iterative operation is in progress
- done  out  1  one-cycle pulse in the cycle hi/lo first show a new mult/div result
- hi  out  WIDTH  HI register (product upper half / remainder)
- lo  out  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, iteration counter=0.
- Reset asserted mid-operation aborts the operation. No partial result reaches hi/lo.
- Op encoding:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 and 111 are NOP.
- States:
  - IDLE: waiting for start.
  - RUN: WIDTH iteration cycles.
  - FIX: sign correction and hi/lo commit.
- IDLE transitions:
  - start=1 with a mult/div op: latch operands; set the counter to WIDTH; set the result-sign flags; go to RUN. busy=1 from the following cycle.
  - start=1 with MTHI: hi<=rs_val on that edge, single cycle, busy stays 0, no done pulse. MTLO does the same for lo.
  - start=1 with a NOP op: no effect.
- Signed ops (MULT/DIV):
  - Operands are converted to magnitude (two's-complement absolute value, as unsigned WIDTH bits) at latch time.
  - Flags are recorded: neg_q = signA XOR signB; neg_r = signA.
- RUN, multiply: shift-add, one multiplier bit per cycle, 2*WIDTH-bit accumulator.
- RUN, divide: restoring division, one quotient bit per cycle; the remainder register is WIDTH+1 bits.
- RUN exit: the counter decrements each cycle; on 0 the state goes to FIX.
- FIX (one cycle):
  - Apply the negations: product negated if neg_q; quotient if neg_q; remainder if neg_r.
  - Write hi/lo, done<=1, busy<=0, next state IDLE.
- Latency: start accepted at edge N; hi/lo/done update at edge N+WIDTH+1 (33 for WIDTH=32). done is high for exactly one cycle.
- hi/lo hold their prior values throughout RUN. Reads during busy return old values; the control path must stall MFHI/MFLO while busy.
- start while busy: ignored, including MTHI/MTLO. No queueing.
- A start presented in the same cycle as the FIX edge is ignored. A new op is accepted from the cycle done is high (state is IDLE then).
- Divide by zero: no trap. Result is hi=rs_val (original, unsigned view), lo=all ones. This is fixed behaviour, independent of signedness.
- Signed overflow, -2^(WIDTH-1) / -1: lo=0x80000000, hi=0. This falls out of the magnitude algorithm and must not be special-cased differently.
- Width rules:
  - Product is the full 2*WIDTH bits: hi = upper half, lo = lower half.
  - All negation is two's complement at the stated width.

Decomposition:
- Shared package mdu_pkg:
  - op encoding localparams OP_MULT..OP_MTLO.
  - State encoding ST_IDLE/ST_RUN/ST_FIX.
  - Default WIDTH.
- One sub-module, mdu_iter_core: a purely combinational single-iteration step.
  - Inputs: accumulator, operand, mode.
  - Outputs: next accumulator.
  - Holds both the shift-add step and the restore-subtract step.
- The FSM, counter, sign handling and HI/LO registers live in mul_div_unit.

Test Plan:
- MULTU: rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001, done pulses one cycle, busy high for exactly 33 cycles.
- MULT: rs=-7 (0xFFFFFFF9), rt=6 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6. DIV: rs=-7, rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU rs=100, rt=0 -> hi=100, lo=0xFFFFFFFF. DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI rs=0x1234 then MTLO rs=0x5678 on consecutive cycles -> hi=0x1234, lo=0x5678 one edge after each; busy never asserts; done stays 0.
- During DIVU 50/7: pulse start with MULTU and with MTLO at cycle 10 -> both ignored; final hi=1, lo=7; hi/lo unchanged during RUN.
- Deassert rst_n at cycle 15 of a MULT, then release -> hi=lo=0, busy=0, done=0 immediately. A subsequent MULTU 3*4 gives lo=12, hi=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM states and the per-iteration mode select.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_e;

endpackage

// File: rtl/mdu_iter_core.sv
// One combinational iteration of the shift-add multiplier or restoring divider.
// Accumulator layout: mult {carry, upper, multiplier}; div {remainder(W+1), quotient(W)}.
module mdu_iter_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [2*WIDTH:0] i_acc,
  input  logic [WIDTH-1:0] i_operand,
  input  mode_e            i_mode,
  output logic [2*WIDTH:0] o_acc
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH+1:0] w_shRem;
  logic [WIDTH+1:0] w_diff;
  logic             w_fits;

  // The extra top bit of w_diff is the borrow: clear means the divisor fits.
  always_comb begin
    w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_operand} : '0);
    w_shRem = {i_acc[2*WIDTH:WIDTH], i_acc[WIDTH-1]};
    w_diff  = w_shRem - {2'b00, i_operand};
    w_fits  = ~w_diff[WIDTH+1];
    if (i_mode == MODE_DIV) begin
      o_acc = {(w_fits ? w_diff[WIDTH:0] : w_shRem[WIDTH:0]), i_acc[WIDTH-2:0], w_fits};
    end else begin
      o_acc = {1'b0, w_sum, i_acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// MIPS-style iterative multiply/divide unit owning HI/LO. Signed ops run on
// magnitudes and are sign-corrected in a single FIX cycle before commit.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_rs_val,
  input  logic [WIDTH-1:0] i_rt_val,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = 2 * WIDTH + 1;

  state_e           r_state;
  mode_e            r_mode;
  logic [CW-1:0]    r_count;
  logic [AW-1:0]    r_acc;
  logic [WIDTH-1:0] r_operand;
  logic             r_negQ;
  logic             r_negR;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;

  logic             w_isMulDiv;
  logic             w_isDivOp;
  logic             w_signedOp;
  logic             w_signA;
  logic             w_signB;
  logic             w_divZero;
  logic [WIDTH-1:0] w_magA;
  logic [WIDTH-1:0] w_magB;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;
  logic [AW-1:0]    w_accNext;

  // Divide by zero keeps the raw dividend and clears the sign flags, so the
  // unsigned-view result (hi=rs, lo=all ones) drops straight out of the loop.
  always_comb begin
    w_isMulDiv = (i_op == OP_MULT) || (i_op == OP_MULTU) ||
                 (i_op == OP_DIV)  || (i_op == OP_DIVU);
    w_isDivOp  = (i_op == OP_DIV) || (i_op == OP_DIVU);
    w_signedOp = (i_op == OP_MULT) || (i_op == OP_DIV);
    w_signA    = w_signedOp & i_rs_val[WIDTH-1];
    w_signB    = w_signedOp & i_rt_val[WIDTH-1];
    w_divZero  = w_isDivOp && (i_rt_val == '0);
    w_magA     = (w_signA && !w_divZero) ? (~i_rs_val + 1'b1) : i_rs_val;
    w_magB     = w_signB ? (~i_rt_val + 1'b1) : i_rt_val;
    w_prod     = r_negQ ? (~r_acc[2*WIDTH-1:0] + 1'b1) : r_acc[2*WIDTH-1:0];
    w_quot     = r_negQ ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
    w_rem      = r_negR ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];
  end

  mdu_iter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .i_acc    (r_acc),
    .i_operand(r_operand),
    .i_mode   (r_mode),
    .o_acc    (w_accNext)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_mode    <= MODE_MUL;
      r_count   <= '0;
      r_acc     <= '0;
      r_operand <= '0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            if (w_isMulDiv) begin
              r_mode    <= w_isDivOp ? MODE_DIV : MODE_MUL;
              r_operand <= w_isDivOp ? w_magB : w_magA;
              r_acc     <= {{(WIDTH + 1){1'b0}}, (w_isDivOp ? w_magA : w_magB)};
              r_negQ    <= (w_signA ^ w_signB) && !w_divZero;
              r_negR    <= w_signA && !w_divZero;
              r_count   <= CW'(WIDTH);
              r_busy    <= 1'b1;
              r_state   <= ST_RUN;
            end else if (i_op == OP_MTHI) begin
              r_hi <= i_rs_val;
            end else if (i_op == OP_MTLO) begin
              r_lo <= i_rs_val;
            end
          end
        end
        ST_RUN: begin
          r_acc   <= w_accNext;
          r_count <= r_count - CW'(1);
          if (r_count == CW'(1)) begin
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (r_mode == MODE_DIV) begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected HI/LO come from native
// 64-bit arithmetic and are popped when done pulses.
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam int WAIT_LIMIT = 60;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  logic [2:0]  i_op;
  logic [31:0] i_rs_val;
  logic [31:0] i_rt_val;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_hi;
  logic [31:0] o_lo;

  int checkCount = 0;
  int errorCount = 0;
  logic [63:0] sbQueue[$];

  mul_div_unit #(.WIDTH(32)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (i_start),
    .i_op    (i_op),
    .i_rs_val(i_rs_val),
    .i_rt_val(i_rt_val),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_hi    (o_hi),
    .o_lo    (o_lo)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference result {hi, lo} computed with plain simulator arithmetic.
  function automatic logic [63:0] modelResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0;
    case (op)
      OP_MULT:  res = 64'(sa * sb);
      OP_MULTU: res = {32'b0, a} * {32'b0, b};
      OP_DIV: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      OP_DIVU: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else            res = {a % b, a / b};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  task automatic startOp(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    sbQueue.push_back(modelResult(op, rs, rt));
    i_start  = 1'b1;
    i_op     = op;
    i_rs_val = rs;
    i_rt_val = rt;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                               input int injectAt, input string tag);
    logic [31:0] hiSnap;
    logic [31:0] loSnap;
    logic [63:0] exp;
    int busyCycles;
    int holdErrs;
    bit seen;
    startOp(op, rs, rt);
    hiSnap = o_hi;
    loSnap = o_lo;
    busyCycles = 0;
    holdErrs = 0;
    seen = 1'b0;
    for (int i = 0; i < WAIT_LIMIT; i++) begin
      if (o_done) begin
        seen = 1'b1;
        break;
      end
      if (o_busy) busyCycles++;
      if (o_hi !== hiSnap || o_lo !== loSnap) holdErrs++;
      if (injectAt > 0 && i == injectAt) begin
        i_start = 1'b1; i_op = OP_MULTU; i_rs_val = 32'd9; i_rt_val = 32'd9;
      end else if (injectAt > 0 && i == injectAt + 1) begin
        i_start = 1'b1; i_op = OP_MTLO; i_rs_val = 32'hDEAD_BEEF;
      end else begin
        i_start = 1'b0;
      end
      @(negedge i_clk);
    end
    i_start = 1'b0;
    exp = sbQueue.pop_front();
    if (!seen) begin
      checkOutput({tag, ".timeout"}, 64'd0, 64'd1);
    end else begin
      checkOutput({tag, ".hi"}, 64'(o_hi), 64'(exp[63:32]));
      checkOutput({tag, ".lo"}, 64'(o_lo), 64'(exp[31:0]));
      checkOutput({tag, ".busyCycles"}, 64'(busyCycles), 64'd33);
      checkOutput({tag, ".hold"}, 64'(holdErrs), 64'd0);
      @(negedge i_clk);
      checkOutput({tag, ".donePulse"}, 64'(o_done), 64'd0);
      checkOutput({tag, ".idleAfter"}, 64'(o_busy), 64'd0);
    end
  endtask

  initial begin
    i_rst_n  = 1'b0;
    i_start  = 1'b0;
    i_op     = 3'b110;
    i_rs_val = '0;
    i_rt_val = '0;
    repeat (2) @(negedge i_clk);
    checkOutput("reset.hi", 64'(o_hi), 64'd0);
    checkOutput("reset.lo", 64'(o_lo), 64'd0);
    checkOutput("reset.busy", 64'(o_busy), 64'd0);
    checkOutput("reset.done", 64'(o_done), 64'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multuMax");
    checkOutput("multuMax.const", {o_hi, o_lo}, 64'hFFFF_FFFE_0000_0001);
    applyStimulus(OP_MULT, 32'hFFFF_FFF9, 32'd6, 0, "multNeg");
    checkOutput("multNeg.const", {o_hi, o_lo}, 64'hFFFF_FFFF_FFFF_FFD6);
    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, "divNeg");
    checkOutput("divNeg.const", {o_hi, o_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    applyStimulus(OP_DIVU, 32'd100, 32'd0, 0, "divuZero");
    checkOutput("divuZero.const", {o_hi, o_lo}, 64'h0000_0064_FFFF_FFFF);
    applyStimulus(OP_DIV, 32'hFFFF_FFFB, 32'd0, 0, "divZeroNeg");
    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, "divOvf");
    checkOutput("divOvf.const", {o_hi, o_lo}, 64'h0000_0000_8000_0000);
    applyStimulus(OP_DIV, 32'd7, 32'hFFFF_FFFE, 0, "divPosNeg");

    // Moves: one edge each, never busy, never done.
    i_start = 1'b1; i_op = OP_MTHI; i_rs_val = 32'h1234;
    @(negedge i_clk);
    checkOutput("mthi.hi", 64'(o_hi), 64'h1234);
    checkOutput("mthi.busy", 64'(o_busy), 64'd0);
    i_op = OP_MTLO; i_rs_val = 32'h5678;
    @(negedge i_clk);
    i_start = 1'b0;
    checkOutput("mtlo.lo", 64'(o_lo), 64'h5678);
    checkOutput("mtlo.hi", 64'(o_hi), 64'h1234);
    checkOutput("mtlo.busy", 64'(o_busy), 64'd0);
    checkOutput("mtlo.done", 64'(o_done), 64'd0);

    applyStimulus(OP_DIVU, 32'd50, 32'd7, 10, "divuInject");
    checkOutput("divuInject.const", {o_hi, o_lo}, 64'h0000_0001_0000_0007);

    // Abort a MULT mid-flight with the asynchronous reset.
    startOp(OP_MULT, 32'hFFFF_FFF9, 32'd6);
    repeat (14) @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    checkOutput("abort.hi", 64'(o_hi), 64'd0);
    checkOutput("abort.lo", 64'(o_lo), 64'd0);
    checkOutput("abort.busy", 64'(o_busy), 64'd0);
    checkOutput("abort.done", 64'(o_done), 64'd0);
    sbQueue = {};
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checkOutput("abort.stillIdle", 64'(o_busy), 64'd0);
    applyStimulus(OP_MULTU, 32'd3, 32'd4, 0, "multuSmall");
    checkOutput("multuSmall.const", {o_hi, o_lo}, 64'h0000_0000_0000_000C);

    for (int k = 0; k < 8; k++) begin
      applyStimulus(3'(k % 4), $urandom, (k == 5) ? 32'd0 : $urandom, 0, "random");
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
